ps2_key_decoder: RTL and testbench
==================================

PS2_KEY_DECODER -- requirements
Module: ps2_key_decoder

Interface
REQ-001 The block SHALL have parameter NUM_KEYS, default 4, giving the number of tracked keys (1..16).
REQ-002 The block SHALL have parameter KEY_CODES, default {9'h029, 9'h174, 9'h16B, 9'h05A}, a packed 9*NUM_KEYS table: entry i in bits [9i+8:9i], bit 8 = E0-extended flag, bits 7:0 = make code (index 0 Enter, 1 Left, 2 Right, 3 Space).
REQ-003 The block SHALL have parameter TIMEOUT_CYCLES, default 50000, the prefix timeout in clocks, used only when KEYDEC_TIMEOUT_EN is defined.
REQ-004 CLOCK_50  input  1  system clock, all state on rising edge.
REQ-005 resetn  input  1  asynchronous, active-low reset.
REQ-006 rx_data  input  8  scan-code byte from the PS/2 controller.
REQ-007 rx_valid  input  1  one-cycle strobe; rx_data is valid only in that cycle.
REQ-008 clear  input  1  synchronous clear of all key state.
REQ-009 key_down  output  NUM_KEYS  level; bit i = key i currently held.
REQ-010 key_press  output  NUM_KEYS  one-cycle pulse on a 0->1 transition of key_down[i].
REQ-011 key_release  output  NUM_KEYS  one-cycle pulse on a 1->0 transition of key_down[i].
REQ-012 any_down  output  1  OR of key_down.
REQ-013 err  output  1  one-cycle pulse on an error or timeout event.

Function
REQ-014 rx_data SHALL be decoded in the same cycle rx_valid is high; it SHALL NOT be taken from a register loaded by a previous strobe.
REQ-015 All outputs SHALL be registered; key_down, key_press, key_release and err SHALL update exactly one cycle after the rx_valid cycle.
REQ-016 The FSM SHALL have states IDLE, EXT, BRK, EXT_BRK and SKIP, and SHALL change state only on rx_valid, clear or timeout.
REQ-017 IDLE transitions: E0->EXT; F0->BRK; E1->SKIP; any other byte->make event (ext=0), stay IDLE.
REQ-018 EXT transitions: F0->EXT_BRK; E0->EXT; any other byte->make event (ext=1)->IDLE.
REQ-019 BRK transitions: E0->EXT_BRK; F0->BRK; any other byte->break event (ext=0)->IDLE.
REQ-020 EXT_BRK transitions: E0 or F0 keep EXT_BRK; any other byte->break event (ext=1)->IDLE.
REQ-021 SKIP (Pause sequence) SHALL discard exactly 7 further bytes, counted by a 3-bit counter, then return to IDLE with no key event.
REQ-022 A make event matching table entry i (ext flag and code both equal) SHALL set key_down[i]; key_press[i] SHALL pulse only if key_down[i] was 0, so typematic repeats produce no pulse.
REQ-023 A break event matching entry i SHALL clear key_down[i]; key_release[i] SHALL pulse only if key_down[i] was 1.
REQ-024 Events matching no entry SHALL have no effect; if several entries match, every matching bit SHALL update.
REQ-025 Byte 00 or FF (controller overrun), in any state, SHALL clear all key_down bits without release pulses, pulse err, and go to IDLE.
REQ-026 Byte AA (keyboard self-test pass) received in IDLE SHALL clear all key_down bits without pulses.
REQ-027 clear SHALL zero key_down, suppress all pulses and force IDLE; if clear and rx_valid are high in the same cycle, clear SHALL win and the byte SHALL be dropped.
REQ-028 key_press and key_release SHALL NOT be asserted in the same cycle for the same bit.

Reset
REQ-029 resetn low SHALL immediately force: FSM IDLE, skip and timeout counters 0, key_down 0, key_press 0, key_release 0, any_down 0, err 0.
REQ-030 Reset asserted mid-sequence (e.g. after E0) SHALL discard the prefix; the first byte after release SHALL be decoded from IDLE.

Configuration
REQ-031 With KEYDEC_TIMEOUT_EN defined, a counter SHALL run in every non-IDLE state, reset on each rx_valid; reaching TIMEOUT_CYCLES-1 SHALL force IDLE and pulse err, with key_down unchanged.
REQ-032 With KEYDEC_TIMEOUT_EN undefined, no timeout counter SHALL exist, and non-IDLE states SHALL persist until the next byte, clear or reset.

Verification
REQ-033 Bytes 5A, 5A, F0, 5A -> key_press[0] pulses once; key_down[0]=1 until the F0,5A pair; then key_release[0] pulses once.
REQ-034 Bytes E0,6B then E0,F0,6B -> key_down[1] rises, then falls; 6B sent without E0 -> no change.
REQ-035 Hold Left (E0,6B), Right (E0,74) -> key_down=4'b0110, any_down=1; byte FF -> key_down=0, err pulses, no release pulses.
REQ-036 Bytes E1,14,77,E1,F0,14,F0,77 then 5A -> Pause ignored; only key_press[0] pulses.
REQ-037 clear and rx_valid(5A) in the same cycle -> key_down stays 0, no pulse; resetn pulsed low after E0, then 74 -> no key event.
REQ-038 KEYDEC_TIMEOUT_EN, TIMEOUT_CYCLES=16: byte E0, then 16 idle cycles, then 6B -> err pulses once; key_down[1] stays 0.

Source files
------------

// File: rtl/ps2_key_decoder.sv
// PS/2 scan-code decoder: tracks NUM_KEYS keys through the make/break/E0/Pause prefix grammar.
// Optional prefix timeout is built only when KEYDEC_TIMEOUT_EN is defined.
module ps2_key_decoder #(
  parameter int                    NUM_KEYS       = 4,
  parameter logic [9*NUM_KEYS-1:0] KEY_CODES      = {9'h029, 9'h174, 9'h16B, 9'h05A},
  parameter int                    TIMEOUT_CYCLES = 50000
) (
  input  logic                CLOCK_50,
  input  logic                resetn,
  input  logic [7:0]          rx_data,
  input  logic                rx_valid,
  input  logic                clear,
  output logic [NUM_KEYS-1:0] key_down,
  output logic [NUM_KEYS-1:0] key_press,
  output logic [NUM_KEYS-1:0] key_release,
  output logic                any_down,
  output logic                err
);

  localparam logic [2:0] IDLE    = 3'd0;
  localparam logic [2:0] EXT     = 3'd1;
  localparam logic [2:0] BRK     = 3'd2;
  localparam logic [2:0] EXT_BRK = 3'd3;
  localparam logic [2:0] SKIP    = 3'd4;

  logic [2:0]          state_q, state_d;
  logic [2:0]          skip_q, skip_d;
  logic [NUM_KEYS-1:0] down_q, down_d;
  logic [NUM_KEYS-1:0] press_q, press_d;
  logic [NUM_KEYS-1:0] rel_q, rel_d;
  logic                any_q, any_d;
  logic                err_q, err_d;
  logic                ev_make, ev_brk, ev_ext;

`ifdef KEYDEC_TIMEOUT_EN
  localparam int TW = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
  logic [TW-1:0] tmo_q, tmo_d;
  logic          tmo_hit;
  assign tmo_hit = (state_q != IDLE) && (tmo_q == TW'(TIMEOUT_CYCLES - 1));
`endif

  always_comb begin
    state_d = state_q;
    skip_d  = skip_q;
    down_d  = down_q;
    press_d = '0;
    rel_d   = '0;
    err_d   = 1'b0;
    ev_make = 1'b0;
    ev_brk  = 1'b0;
    ev_ext  = 1'b0;
    if (clear) begin
      state_d = IDLE;
      skip_d  = '0;
      down_d  = '0;
    end else if (rx_valid) begin
      // Controller overrun aborts whatever sequence is in flight.
      if (rx_data == 8'h00 || rx_data == 8'hFF) begin
        state_d = IDLE;
        skip_d  = '0;
        down_d  = '0;
        err_d   = 1'b1;
      end else begin
        case (state_q)
          IDLE: begin
            if (rx_data == 8'hE0)      state_d = EXT;
            else if (rx_data == 8'hF0) state_d = BRK;
            else if (rx_data == 8'hE1) begin
              state_d = SKIP;
              skip_d  = '0;
            end else if (rx_data == 8'hAA) down_d = '0;
            else ev_make = 1'b1;
          end
          EXT: begin
            if (rx_data == 8'hF0)      state_d = EXT_BRK;
            else if (rx_data != 8'hE0) begin
              ev_make = 1'b1;
              ev_ext  = 1'b1;
              state_d = IDLE;
            end
          end
          BRK: begin
            if (rx_data == 8'hE0)      state_d = EXT_BRK;
            else if (rx_data != 8'hF0) begin
              ev_brk  = 1'b1;
              state_d = IDLE;
            end
          end
          EXT_BRK: begin
            if (rx_data != 8'hE0 && rx_data != 8'hF0) begin
              ev_brk  = 1'b1;
              ev_ext  = 1'b1;
              state_d = IDLE;
            end
          end
          SKIP: begin
            // Pause sends E1 plus seven more bytes; the seventh ends the skip.
            if (skip_q == 3'd6) begin
              state_d = IDLE;
              skip_d  = '0;
            end else begin
              skip_d = skip_q + 3'd1;
            end
          end
          default: state_d = IDLE;
        endcase
      end
    end
`ifdef KEYDEC_TIMEOUT_EN
    else if (tmo_hit) begin
      state_d = IDLE;
      skip_d  = '0;
      err_d   = 1'b1;
    end
`endif
    for (int i = 0; i < NUM_KEYS; i++) begin
      if (KEY_CODES[9*i +: 9] == {ev_ext, rx_data}) begin
        if (ev_make) begin
          press_d[i] = ~down_q[i];
          down_d[i]  = 1'b1;
        end else if (ev_brk) begin
          rel_d[i]  = down_q[i];
          down_d[i] = 1'b0;
        end
      end
    end
    any_d = |down_d;
  end

`ifdef KEYDEC_TIMEOUT_EN
  always_comb begin
    if (clear || rx_valid || state_q == IDLE || tmo_hit) tmo_d = '0;
    else                                                tmo_d = tmo_q + 1'b1;
  end

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) tmo_q <= '0;
    else         tmo_q <= tmo_d;
  end
`endif

  always_ff @(posedge CLOCK_50 or negedge resetn) begin
    if (!resetn) begin
      state_q <= IDLE;
      skip_q  <= '0;
      down_q  <= '0;
      press_q <= '0;
      rel_q   <= '0;
      any_q   <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      skip_q  <= skip_d;
      down_q  <= down_d;
      press_q <= press_d;
      rel_q   <= rel_d;
      any_q   <= any_d;
      err_q   <= err_d;
    end
  end

  assign key_down    = down_q;
  assign key_press   = press_q;
  assign key_release = rel_q;
  assign any_down    = any_q;
  assign err         = err_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// Scoreboard bench for ps2_key_decoder: a prefix-flag reference model predicts each cycle's outputs.
module tb_ps2_key_decoder;
  localparam int TMO = 16;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [7:0] rx_data = '0;
  logic       rx_valid = 1'b0;
  logic       clear = 1'b0;
  logic [3:0] key_down, key_press, key_release;
  logic       any_down, err;

  ps2_key_decoder #(.NUM_KEYS(4), .TIMEOUT_CYCLES(TMO)) dut (
    .CLOCK_50(clk), .resetn(resetn), .rx_data(rx_data), .rx_valid(rx_valid),
    .clear(clear), .key_down(key_down), .key_press(key_press),
    .key_release(key_release), .any_down(any_down), .err(err)
  );

  always #5 clk = ~clk;

  typedef struct packed {
    logic [3:0] down;
    logic [3:0] press;
    logic [3:0] rel;
    logic       any;
    logic       err;
  } exp_t;

  exp_t exp_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model: prefix seen so far as flags, bytes left to skip, idle time.
  bit         m_ext, m_brk;
  int         m_skip, m_idle;
  logic [3:0] m_down;
  logic [8:0] tbl [4];

  initial begin
    tbl[0] = 9'h05A; tbl[1] = 9'h16B; tbl[2] = 9'h174; tbl[3] = 9'h029;
  end

  task automatic model_reset();
    m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0; m_down = '0;
  endtask

  task automatic model(input bit v, input logic [7:0] d, input bit clr);
    exp_t e;
    e = '0;
    if (clr) begin
      model_reset();
    end else if (v) begin
      m_idle = 0;
      if (d == 8'h00 || d == 8'hFF) begin
        m_down = '0; m_ext = 0; m_brk = 0; m_skip = 0; e.err = 1'b1;
      end else if (m_skip > 0) begin
        m_skip--;
      end else if (d == 8'hE0) begin
        m_ext = 1;
      end else if (d == 8'hF0) begin
        m_brk = 1;
      end else if (!m_ext && !m_brk && d == 8'hE1) begin
        m_skip = 7;
      end else if (!m_ext && !m_brk && d == 8'hAA) begin
        m_down = '0;
      end else begin
        for (int i = 0; i < 4; i++) begin
          if (tbl[i] == {m_ext, d}) begin
            if (m_brk) begin e.rel[i] = m_down[i];    m_down[i] = 1'b0; end
            else       begin e.press[i] = !m_down[i]; m_down[i] = 1'b1; end
          end
        end
        m_ext = 0; m_brk = 0;
      end
    end
`ifdef KEYDEC_TIMEOUT_EN
    else if (m_ext || m_brk || m_skip > 0) begin
      m_idle++;
      if (m_idle == TMO) begin
        m_ext = 0; m_brk = 0; m_skip = 0; m_idle = 0; e.err = 1'b1;
      end
    end
`endif
    e.down = m_down;
    e.any  = |m_down;
    exp_q.push_back(e);
  endtask

  task automatic step(input bit v, input logic [7:0] d, input bit clr);
    @(negedge clk);
    rx_valid = v; rx_data = d; clear = clr;
    model(v, d, clr);
  endtask

  task automatic send(input logic [7:0] d);
    step(1'b1, d, 1'b0);
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, $urandom_range(0, 255), 1'b0);
  endtask

  task automatic do_reset();
    @(negedge clk);
    rx_valid = 1'b0; clear = 1'b0; resetn = 1'b0;
    model_reset();
    #1;
    n_tests++;
    if ({key_down, key_press, key_release, any_down, err} !== '0) begin
      n_fail++;
      $display("FAIL reset_state: got down=%b press=%b rel=%b any=%b err=%b, want all zero",
               key_down, key_press, key_release, any_down, err);
    end
    @(negedge clk);
    resetn = 1'b1;
  endtask

  // Monitor: each registered output set is compared one cycle after its stimulus.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        n_tests++;
        if (key_down !== e.down || key_press !== e.press || key_release !== e.rel ||
            any_down !== e.any || err !== e.err) begin
          n_fail++;
          $display("FAIL outputs @%0t: got down=%b press=%b rel=%b any=%b err=%b, want down=%b press=%b rel=%b any=%b err=%b",
                   $time, key_down, key_press, key_release, any_down, err,
                   e.down, e.press, e.rel, e.any, e.err);
        end
      end
    end
  end

  initial begin
    int r;
    logic [7:0] pool [12];
    pool = '{8'h5A, 8'h6B, 8'h74, 8'h29, 8'hE0, 8'hE0, 8'hF0, 8'hF0,
             8'hE1, 8'hAA, 8'h14, 8'h77};
    model_reset();
    do_reset();

    // Enter make, typematic repeat, break
    send(8'h5A); send(8'h5A); send(8'hF0); send(8'h5A); idle(2);
    // Left extended, then unextended 6B ignored
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'hF0); send(8'h6B); send(8'h6B); idle(2);
    // Left+Right held, overrun clears without release
    send(8'hE0); send(8'h6B); send(8'hE0); send(8'h74); send(8'hFF); idle(2);
    // Pause sequence is swallowed
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1); send(8'hF0); send(8'h14);
    send(8'hF0); send(8'h77); send(8'h5A); idle(1);
    // Self-test pass clears, overrun 00
    send(8'hAA); send(8'h29); send(8'h00); idle(1);
    // Clear beats a simultaneous byte
    send(8'hF0); send(8'h5A); step(1'b1, 8'h5A, 1'b1); idle(2);
    // Reset discards a pending E0
    send(8'hE0); idle(1);
    do_reset();
    send(8'h74); idle(2);
    // Long idle gap inside a prefix
    send(8'hE0); idle(TMO); send(8'h6B); idle(2);
    send(8'hE0); send(8'hF0); send(8'h6B); idle(1);

    for (int n = 0; n < 3000; n++) begin
      r = $urandom_range(0, 99);
      if (r < 4)       step(1'b0, 8'h00, 1'b1);
      else if (r < 6)  send(($urandom_range(0, 1) != 0) ? 8'hFF : 8'h00);
      else if (r < 8)  idle($urandom_range(TMO - 2, TMO + 3));
      else if (r < 30) idle(1);
      else if (r < 35) send(8'($urandom_range(0, 255)));
      else             send(pool[$urandom_range(0, 11)]);
    end

    idle(3);
    repeat (3) @(negedge clk);
    n_tests++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL scoreboard_drain: got %0d pending entries, want 0", exp_q.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
